window_3x3_stream: RTL and testbench

//  Downstream neighbour of the 4:5 bilinear scaler. Consumes its raster pixel stream
//  (valid, pixel, x, y), which may have idle gaps. Emits every fully interior 3x3

---
 rtl/window_3x3_stream_pkg.sv | 26 ++
 rtl/window_3x3_stream_if.sv | 34 +++
 rtl/window_3x3_stream_line_buffer.sv | 46 ++++
 rtl/window_3x3_stream.sv | 250 +++++++++++++++++++++++++
 tb/tb_window_3x3_stream.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/window_3x3_stream_pkg.sv
// -----------------------------------------------------------------------------
// window3_pkg
// Shared types and helpers for the 3x3 window streamer.
//   win3_state_t : frame-tracking FSM states
//   WIN3_TAPS    : number of pixels in one window
//   WIN3_CENTRE  : tap index of the centre pixel
//   win3_idx     : bit offset of tap (r,c) inside the packed window bus
// -----------------------------------------------------------------------------
package window3_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ROW0     = 2'd1,
    ROW1     = 2'd2,
    STREAM   = 2'd3
  } win3_state_t;

  localparam int WIN3_TAPS   = 9;
  localparam int WIN3_CENTRE = 4;

  // Row 0 is the oldest row (top), column 0 the oldest column (left).
  function automatic int win3_idx(input int r, input int c, input int luma_bits = 8);
    return ((r * 3) + c) * luma_bits;
  endfunction

endpackage

// File: rtl/window_3x3_stream_if.sv
// -----------------------------------------------------------------------------
// window_3x3_stream_if
// Pixel-in / window-out bundle of the 3x3 window streamer.
//   in_valid/in_pixel/in_x/in_y   : raster pixel stream, no backpressure
//   out_valid/out_window/out_x/y  : one-cycle window pulse with centre coordinate
// Modports: master = stream source / window sink, slave = the window block.
// -----------------------------------------------------------------------------
interface window_3x3_stream_if
  import window3_pkg::*;
#(
  parameter int LUMA_BITS  = 8,
  parameter int COORD_BITS = 16
);

  logic                              in_valid;
  logic [LUMA_BITS-1:0]              in_pixel;
  logic [COORD_BITS-1:0]             in_x;
  logic [COORD_BITS-1:0]             in_y;
  logic                              out_valid;
  logic [WIN3_TAPS*LUMA_BITS-1:0]    out_window;
  logic [COORD_BITS-1:0]             out_x;
  logic [COORD_BITS-1:0]             out_y;

  modport master (
    output in_valid, in_pixel, in_x, in_y,
    input  out_valid, out_window, out_x, out_y
  );

  modport slave (
    input  in_valid, in_pixel, in_x, in_y,
    output out_valid, out_window, out_x, out_y
  );

endinterface

// File: rtl/window_3x3_stream_line_buffer.sv
// -----------------------------------------------------------------------------
// window3_line_buffer
// One-read-port / one-write-port synchronous RAM holding the two previous rows
// of the stream as {row y-1, row y-2} per column. Read-first: a read and a
// write to the same address in one cycle return the old contents.
// Contents are not reset.
//   clk      : rising-edge clock
//   rd_en    : read strobe, rd_addr : read address, rd_data : registered data
//   wr_en    : write strobe, wr_addr : write address, wr_data : write data
// -----------------------------------------------------------------------------
module window3_line_buffer #(
  parameter int DEPTH     = 2048,
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Registered read port; holds its value when not strobed.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/window_3x3_stream.sv
// -----------------------------------------------------------------------------
// window_3x3_stream
// Turns a raster pixel stream (with idle gaps, no backpressure) into every
// fully interior 3x3 neighbourhood, tagged with its centre coordinate.
// Border pixels produce no window. Latency: pixel sampled at edge N gives its
// window (if any) registered at edge N+2.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   r_width  : row width (3..MAX_INPUT_WIDTH), static within a frame
//   strm     : window_3x3_stream_if.slave (pixel in, window out)
//   err_seq  : sticky coordinate-sequence error (only with WINDOW3_SEQ_CHECK_EN)
// Build option: define WINDOW3_SEQ_CHECK_EN to add the expected-coordinate
// tracker; an out-of-sequence pixel is dropped, raises err_seq and forces the
// FSM back to WAIT_SOF.
// -----------------------------------------------------------------------------
module window_3x3_stream
  import window3_pkg::*;
#(
  parameter int LUMA_BITS       = 8,
  parameter int MAX_INPUT_WIDTH = 2048,
  parameter int COORD_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] r_width,
  window_3x3_stream_if.slave    strm
`ifdef WINDOW3_SEQ_CHECK_EN
  ,
  output logic                  err_seq
`endif
);

  localparam int ADDR_BITS = (MAX_INPUT_WIDTH > 1) ? $clog2(MAX_INPUT_WIDTH) : 1;
  localparam int RAM_BITS  = 2 * LUMA_BITS;
  localparam int WIN_BITS  = WIN3_TAPS * LUMA_BITS;
  localparam logic [COORD_BITS-1:0] COORD_ZERO = {COORD_BITS{1'b0}};
  localparam logic [COORD_BITS-1:0] COORD_ONE  = {{(COORD_BITS-1){1'b0}}, 1'b1};

  // Input stage
  win3_state_t           state_q;
  win3_state_t           pix_state_s;   // state the current pixel belongs to
  logic                  sof_s;
  logic                  row_end_s;
  logic                  seq_bad_s;
  logic                  accept_s;

  // Stage 1 (pixel registered, RAM read data available)
  logic                  v1_q;
  logic                  stream1_q;
  logic [LUMA_BITS-1:0]  pix1_q;
  logic [COORD_BITS-1:0] x1_q;
  logic [COORD_BITS-1:0] y1_q;
  logic [RAM_BITS-1:0]   rd_data_s;     // {row y-1, row y-2}

  // Stage 2 (column taps)
  logic [LUMA_BITS-1:0]  tap_q [3][3];  // [row][col]
  logic [1:0]            fill_q;
  logic [1:0]            fill_d;
  logic                  fire2_q;
  logic [COORD_BITS-1:0] x2_q;
  logic [COORD_BITS-1:0] y2_q;
  logic [WIN_BITS-1:0]   window_s;

  // Output registers
  logic                  out_valid_q;
  logic [WIN_BITS-1:0]   out_window_q;
  logic [COORD_BITS-1:0] out_x_q;
  logic [COORD_BITS-1:0] out_y_q;

`ifdef WINDOW3_SEQ_CHECK_EN
  logic [COORD_BITS-1:0] exp_x_q;
  logic [COORD_BITS-1:0] exp_y_q;
  logic                  bad1_q;
  logic                  err_seq_q;
`endif

  // Classify the incoming pixel; an SOF pixel always belongs to a fresh ROW0.
  always_comb begin
    sof_s     = (strm.in_x == COORD_ZERO) && (strm.in_y == COORD_ZERO);
    row_end_s = (strm.in_x == (r_width - COORD_ONE));
    if (sof_s) begin
      pix_state_s = ROW0;
    end else begin
      pix_state_s = state_q;
    end
`ifdef WINDOW3_SEQ_CHECK_EN
    if (strm.in_valid && !sof_s && (state_q != WAIT_SOF) &&
        ((strm.in_x != exp_x_q) || (strm.in_y != exp_y_q))) begin
      seq_bad_s = 1'b1;
    end else begin
      seq_bad_s = 1'b0;
    end
`else
    seq_bad_s = 1'b0;
`endif
    accept_s = strm.in_valid && (pix_state_s != WAIT_SOF) && !seq_bad_s;
  end

  // Frame FSM and stage-1 pixel register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_SOF;
      v1_q      <= 1'b0;
      stream1_q <= 1'b0;
      pix1_q    <= {LUMA_BITS{1'b0}};
      x1_q      <= COORD_ZERO;
      y1_q      <= COORD_ZERO;
    end else begin
      v1_q <= accept_s;
      if (seq_bad_s) begin
        state_q <= WAIT_SOF;
      end else if (accept_s) begin
        pix1_q    <= strm.in_pixel;
        x1_q      <= strm.in_x;
        y1_q      <= strm.in_y;
        stream1_q <= (pix_state_s == STREAM);
        case (pix_state_s)
          ROW0:    state_q <= row_end_s ? ROW1 : ROW0;
          ROW1:    state_q <= row_end_s ? STREAM : ROW1;
          STREAM:  state_q <= STREAM;
          default: state_q <= WAIT_SOF;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

`ifdef WINDOW3_SEQ_CHECK_EN
  // Expected-coordinate tracker and sticky sequence error (one edge late).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_x_q   <= COORD_ZERO;
      exp_y_q   <= COORD_ZERO;
      bad1_q    <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      bad1_q    <= seq_bad_s;
      err_seq_q <= err_seq_q | bad1_q;
      if (accept_s && row_end_s) begin
        exp_x_q <= COORD_ZERO;
        exp_y_q <= strm.in_y + COORD_ONE;
      end else if (accept_s) begin
        exp_x_q <= strm.in_x + COORD_ONE;
        exp_y_q <= strm.in_y;
      end else begin
        exp_x_q <= exp_x_q;
        exp_y_q <= exp_y_q;
      end
    end
  end

  assign err_seq = err_seq_q;
`endif

  // Read column x in stage 0, write it back one cycle later with the rows
  // shifted down; the write address always trails the read address by one
  // column, so the two never collide for r_width >= 3.
  window3_line_buffer #(
    .DEPTH     (MAX_INPUT_WIDTH),
    .WIDTH     (RAM_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_line_buffer (
    .clk     (clk),
    .rd_en   (accept_s),
    .rd_addr (strm.in_x[ADDR_BITS-1:0]),
    .rd_data (rd_data_s),
    .wr_en   (v1_q),
    .wr_addr (x1_q[ADDR_BITS-1:0]),
    .wr_data ({pix1_q, rd_data_s[RAM_BITS-1 -: LUMA_BITS]})
  );

  // Column fill count: columns of the current row present in the taps.
  always_comb begin
    if (x1_q == COORD_ZERO) begin
      fill_d = 2'd0;
    end else if (fill_q == 2'd2) begin
      fill_d = 2'd2;
    end else begin
      fill_d = fill_q + 2'd1;
    end
  end

  // Column shift register; newest column enters at col 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_q[r][c] <= {LUMA_BITS{1'b0}};
        end
      end
      fill_q  <= 2'd0;
      fire2_q <= 1'b0;
      x2_q    <= COORD_ZERO;
      y2_q    <= COORD_ZERO;
    end else if (v1_q) begin
      for (int r = 0; r < 3; r++) begin
        tap_q[r][0] <= tap_q[r][1];
        tap_q[r][1] <= tap_q[r][2];
      end
      tap_q[0][2] <= rd_data_s[LUMA_BITS-1:0];
      tap_q[1][2] <= rd_data_s[RAM_BITS-1 -: LUMA_BITS];
      tap_q[2][2] <= pix1_q;
      fill_q      <= fill_d;
      fire2_q     <= stream1_q && (fill_d == 2'd2);
      x2_q        <= x1_q;
      y2_q        <= y1_q;
    end else begin
      fire2_q <= 1'b0;
    end
  end

  // Pack the taps into the output bus layout.
  always_comb begin
    window_s = {WIN_BITS{1'b0}};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window_s[win3_idx(r, c, LUMA_BITS) +: LUMA_BITS] = tap_q[r][c];
      end
    end
  end

  // Output registers; window and coordinates hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_window_q <= {WIN_BITS{1'b0}};
      out_x_q      <= COORD_ZERO;
      out_y_q      <= COORD_ZERO;
    end else begin
      out_valid_q <= fire2_q;
      if (fire2_q) begin
        out_window_q <= window_s;
        out_x_q      <= x2_q - COORD_ONE;
        out_y_q      <= y2_q - COORD_ONE;
      end else begin
        out_window_q <= out_window_q;
        out_x_q      <= out_x_q;
        out_y_q      <= out_y_q;
      end
    end
  end

  assign strm.out_valid  = out_valid_q;
  assign strm.out_window = out_window_q;
  assign strm.out_x      = out_x_q;
  assign strm.out_y      = out_y_q;

endmodule

// File: tb/tb_window_3x3_stream.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_stream
// Scoreboard bench: each driven pixel that completes an interior window pushes
// the expected window, centre and arrival cycle; the monitor pops and compares
// on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_window_3x3_stream;
  import window3_pkg::*;

  typedef struct {
    int           x;
    int           y;
    logic [71:0]  win;
    longint       cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  r_width = 16'd5;
  longint       cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  exp_t         sb_q[$];
`ifdef WINDOW3_SEQ_CHECK_EN
  logic         err_seq;
`endif

  window_3x3_stream_if #(.LUMA_BITS(8), .COORD_BITS(16)) bus ();

  window_3x3_stream #(
    .LUMA_BITS       (8),
    .MAX_INPUT_WIDTH (2048),
    .COORD_BITS      (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .r_width (r_width),
    .strm    (bus)
`ifdef WINDOW3_SEQ_CHECK_EN
    ,
    .err_seq (err_seq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y, input logic [7:0] base);
    return 8'((16 * y) + x) + base;
  endfunction

  function automatic logic [71:0] mkwin(input int cx, input int cy, input logic [7:0] base);
    logic [71:0] w;
    w = 72'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[win3_idx(r, c, 8) +: 8] = pix(cx - 1 + c, cy - 1 + r, base);
      end
    end
    return w;
  endfunction

  task automatic drive_px(input int x, input int y, input logic [7:0] base, input bit push);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = pix(x, y, base);
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
    if (push && (x >= 2) && (y >= 2)) begin
      e.x   = x - 1;
      e.y   = y - 1;
      e.win = mkwin(x - 1, y - 1, base);
      e.cyc = cyc + 3;   // sampled at next edge N, visible after edge N+2
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int w, input int h, input logic [7:0] base, input bit gappy);
    int n;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        drive_px(x, y, base, 1'b1);
        n++;
        if (gappy && ((n % 4) == 0)) idle(1);
      end
    end
  endtask

  // Output monitor: every pulse must match the oldest expected window.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_out", 72'(bus.out_valid), 72'(0));
      end else begin
        e = sb_q.pop_front();
        check_eq("out_x", 72'(bus.out_x), 72'(e.x));
        check_eq("out_y", 72'(bus.out_y), 72'(e.y));
        check_eq("out_window", bus.out_window, e.win);
        check_eq("latency", 72'(cyc), 72'(e.cyc));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pixel = 8'd0;
    bus.in_x     = 16'd0;
    bus.in_y     = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid",  72'(bus.out_valid), 72'(0));
    check_eq("rst_window", bus.out_window, 72'(0));
    check_eq("rst_x",      72'(bus.out_x), 72'(0));
    check_eq("rst_y",      72'(bus.out_y), 72'(0));
    reset = 1'b1;
    idle(2);

    // 5x4 gapless frame: six windows, first centre (1,1).
    r_width = 16'd5;
    send_frame(5, 4, 8'h00, 1'b0);
    idle(5);
    check_eq("t1_drain", 72'(sb_q.size()), 72'(0));
    check_eq("t1_hold_x", 72'(bus.out_x), 72'(3));

    // Full-width rows with in_valid 4 of every 5 cycles.
    r_width = 16'd981;
    send_frame(981, 6, 8'h33, 1'b1);
    idle(5);
    check_eq("t2_drain", 72'(sb_q.size()), 72'(0));

    // Back-to-back frames; frame B windows must hold only B data.
    r_width = 16'd5;
    send_frame(5, 4, 8'h00, 1'b0);
    send_frame(5, 4, 8'h80, 1'b0);
    idle(5);
    check_eq("t4_drain", 72'(sb_q.size()), 72'(0));

    // Minimum width: three windows down a single column of centres.
    r_width = 16'd3;
    send_frame(3, 5, 8'h11, 1'b0);
    idle(5);
    check_eq("t5_drain", 72'(sb_q.size()), 72'(0));

    // Reset during row 3, stream resumes at row 4, then a fresh frame.
    r_width = 16'd6;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 6; x++) drive_px(x, y, 8'h40, 1'b1);
    for (int x = 0; x < 3; x++) drive_px(x, 3, 8'h40, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_eq("rst_mid_valid", 72'(bus.out_valid), 72'(0));
    check_eq("rst_mid_x",     72'(bus.out_x), 72'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int y = 4; y < 7; y++)
      for (int x = 0; x < 6; x++) drive_px(x, y, 8'h40, 1'b0);
    idle(3);
    send_frame(6, 4, 8'h20, 1'b0);
    idle(5);
    check_eq("t3_drain", 72'(sb_q.size()), 72'(0));

`ifdef WINDOW3_SEQ_CHECK_EN
    // Pixel (7,3) missing: error one edge after (8,3), nothing more that frame.
    r_width = 16'd12;
    check_eq("t6_err_init", 72'(err_seq), 72'(0));
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 12; x++) begin
        if (!((y == 3) && (x == 7))) begin
          drive_px(x, y, 8'h00, (y < 3) || ((y == 3) && (x < 7)));
          if ((y == 3) && (x == 8)) begin
            @(posedge clk);
            #1;
            check_eq("t6_err_early", 72'(err_seq), 72'(0));
            @(posedge clk);
            #1;
            check_eq("t6_err_set", 72'(err_seq), 72'(1));
          end
        end
      end
    end
    idle(5);
    check_eq("t6_err_sticky", 72'(err_seq), 72'(1));
    send_frame(12, 4, 8'h55, 1'b0);
    idle(5);
    check_eq("t6_drain", 72'(sb_q.size()), 72'(0));
    check_eq("t6_err_final", 72'(err_seq), 72'(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
